// File: rtl/dice_dispatch_pkg.sv
// Shared dispatcher types and the lane<->global thread index mapping.
// The forward and reverse mapper paths both use this package.
package dice_dispatch_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 4;
    localparam int CHUNK_W   = NUM_LANES * LANE_W;
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        UF1 = 2'd0,
        UF2 = 2'd1,
        UF4 = 2'd2
    } unroll_e;

    // Returns the global thread index of bit 'pos' in lane 'lane' for a given unroll factor.
    // The illegal code 3 falls back to the identity layout; those chunks are never emitted.
    function automatic logic [7:0] lane_to_global(input logic [1:0] lane,
                                                  input logic [5:0] pos,
                                                  input logic [1:0] uf);
        logic [7:0] g;
        case (uf)
            UF1:     g = {lane, pos};
            UF2:     g = {lane[1], pos[5:4], lane[0], pos[3:0]};
            UF4:     g = {pos[5:3], lane, pos[2:0]};
            default: g = {lane, pos};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lane_popcount64.sv
// Population count of one 64-bit lane mask (0..64).
module lane_popcount64
    import dice_dispatch_pkg::*;
(
    input  logic [LANE_W-1:0] mask,
    output logic [CNT_W-1:0]  cnt
);

    logic [CNT_W-1:0] cnt_s;

    // Adder chain over all mask bits.
    always_comb begin
        cnt_s = '0;
        for (int i = 0; i < LANE_W; i++) begin
            cnt_s = cnt_s + CNT_W'(mask[i]);
        end
    end

    assign cnt = cnt_s;

endmodule

// File: rtl/active_mask_lane_mapper.sv
// Splits 256-bit active-mask chunks into four 64-bit lane masks (two-stage
// valid/ready pipeline) and annotates each lane with count, any-flag and chunk index.
module active_mask_lane_mapper
    import dice_dispatch_pkg::*;
#(
    parameter int CHUNK_IDX_W = 4,
    parameter bit SKIP_EMPTY  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W-1:0]            in_mask,
    input  logic [1:0]                    in_uf,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*LANE_W-1:0]   out_lane_mask,
    output logic [NUM_LANES*CNT_W-1:0]    out_lane_cnt,
    output logic [NUM_LANES-1:0]          out_lane_any,
    output logic [CHUNK_IDX_W-1:0]        out_chunk_idx,
    output logic [1:0]                    out_uf,
    output logic                          out_last,
    output logic                          cfg_err
);

    logic [CHUNK_W-1:0]           map_s;
    logic                         in_zero_s, in_bad_s, in_drop_s, accept_s;
    logic                         s1_adv_s, s2_adv_s, s1_emit_s;
    logic [NUM_LANES*CNT_W-1:0]   pop_s;
    logic [NUM_LANES-1:0]         any_s;

    logic                         s1_v_r, s1_drop_r, s1_last_r, cfg_err_r;
    logic [CHUNK_W-1:0]           s1_mask_r;
    logic [1:0]                   s1_uf_r;
    logic [CHUNK_IDX_W-1:0]       s1_idx_r, idx_cnt_r;

    logic                         s2_v_r, s2_last_r;
    logic [CHUNK_W-1:0]           s2_mask_r;
    logic [NUM_LANES*CNT_W-1:0]   s2_cnt_r;
    logic [NUM_LANES-1:0]         s2_any_r;
    logic [CHUNK_IDX_W-1:0]       s2_idx_r;
    logic [1:0]                   s2_uf_r;

    // Gather each lane bit from its global position.
    always_comb begin
        map_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int p = 0; p < LANE_W; p++) begin
                map_s[l*LANE_W + p] = in_mask[lane_to_global(2'(l), 6'(p), in_uf)];
            end
        end
    end

    // Empty non-last chunks and illegal-uf chunks pass through S1 only.
    assign in_zero_s = (in_mask == '0);
    assign in_bad_s  = (in_uf == 2'd3);
    assign in_drop_s = in_bad_s || (SKIP_EMPTY && in_zero_s && !in_last);

    assign s1_emit_s = s1_v_r && !s1_drop_r;
    assign s2_adv_s  = !s2_v_r || out_ready;
    assign s1_adv_s  = !s1_v_r || (s2_adv_s && s1_emit_s) || (s1_v_r && s1_drop_r);
    assign accept_s  = in_valid && s1_adv_s;
    assign in_ready  = s1_adv_s;

    // Chunk index counter: counts every accepted chunk, restarts after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt_r <= '0;
        end else if (accept_s) begin
            idx_cnt_r <= in_last ? '0 : idx_cnt_r + CHUNK_IDX_W'(1);
        end
    end

    // S1: mapped masks and sideband; cfg_err is high exactly while a bad chunk sits here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r    <= 1'b0;
            s1_drop_r <= 1'b0;
            cfg_err_r <= 1'b0;
            s1_mask_r <= '0;
            s1_uf_r   <= 2'd0;
            s1_last_r <= 1'b0;
            s1_idx_r  <= '0;
        end else if (s1_adv_s) begin
            s1_v_r    <= in_valid;
            s1_drop_r <= in_valid && in_drop_s;
            cfg_err_r <= in_valid && in_bad_s;
            if (in_valid) begin
                s1_mask_r <= map_s;
                s1_uf_r   <= in_uf;
                s1_last_r <= in_last;
                s1_idx_r  <= idx_cnt_r;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_popcount64 u_pop (
            .mask (s1_mask_r[gi*LANE_W +: LANE_W]),
            .cnt  (pop_s[gi*CNT_W +: CNT_W])
        );
        assign any_s[gi] = |s1_mask_r[gi*LANE_W +: LANE_W];
    end

    // S2: output register, holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            s2_mask_r <= '0;
            s2_cnt_r  <= '0;
            s2_any_r  <= '0;
            s2_idx_r  <= '0;
            s2_uf_r   <= 2'd0;
            s2_last_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_v_r <= s1_emit_s;
            if (s1_emit_s) begin
                s2_mask_r <= s1_mask_r;
                s2_cnt_r  <= pop_s;
                s2_any_r  <= any_s;
                s2_idx_r  <= s1_idx_r;
                s2_uf_r   <= s1_uf_r;
                s2_last_r <= s1_last_r;
            end
        end
    end

    assign out_valid     = s2_v_r;
    assign out_lane_mask = s2_mask_r;
    assign out_lane_cnt  = s2_cnt_r;
    assign out_lane_any  = s2_any_r;
    assign out_chunk_idx = s2_idx_r;
    assign out_uf        = s2_uf_r;
    assign out_last      = s2_last_r;
    assign cfg_err       = cfg_err_r;

endmodule

// File: tb/tb_active_mask_lane_mapper.sv
// Scoreboard bench for active_mask_lane_mapper: directed scenarios plus random traffic,
// expected lane masks built by scattering global bits with plain index arithmetic.
module tb_active_mask_lane_mapper;
    import dice_dispatch_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [255:0]  in_mask = '0;
    logic [1:0]    in_uf = 2'd0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [255:0]  out_lane_mask;
    logic [27:0]   out_lane_cnt;
    logic [3:0]    out_lane_any;
    logic [3:0]    out_chunk_idx;
    logic [1:0]    out_uf;
    logic          out_last;
    logic          cfg_err;

    active_mask_lane_mapper dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_uf(in_uf), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane_mask(out_lane_mask),
        .out_lane_cnt(out_lane_cnt), .out_lane_any(out_lane_any), .out_chunk_idx(out_chunk_idx),
        .out_uf(out_uf), .out_last(out_last), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] mask;
        logic [27:0]  cnt;
        logic [3:0]   any;
        logic [3:0]   idx;
        logic [1:0]   uf;
        logic         last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    int   exp_err = 0;
    int   seen_err = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    function automatic void check(string name, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference model: scatter each global bit g to its (lane, position) by arithmetic.
    function automatic void model_accept(logic [255:0] m, logic [1:0] uf, logic last);
        exp_t e;
        int lane, pos, c;
        e.idx = 4'(model_cnt);
        model_cnt = last ? 0 : (model_cnt + 1) % 16;
        if (uf == 2'd3) begin
            exp_err++;
            return;
        end
        if (m == '0 && !last) return;
        e.mask = '0;
        for (int g = 0; g < 256; g++) begin
            if (uf == 2'd0) begin
                lane = g / 64;
                pos  = g % 64;
            end else if (uf == 2'd1) begin
                lane = 2 * (g / 128) + (g / 16) % 2;
                pos  = ((g / 32) % 4) * 16 + g % 16;
            end else begin
                lane = (g / 8) % 4;
                pos  = (g / 32) * 8 + g % 8;
            end
            if (m[g]) e.mask[lane*64 + pos] = 1'b1;
        end
        e.cnt = '0;
        e.any = '0;
        for (int l = 0; l < 4; l++) begin
            c = $countones(e.mask[l*64 +: 64]);
            e.cnt[l*7 +: 7] = 7'(c);
            e.any[l] = (c != 0);
        end
        e.uf = uf;
        e.last = last;
        sb_q.push_back(e);
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: counts cfg_err pulses, checks stall stability and pops the scoreboard.
    logic [255:0] hold_mask;
    logic [3:0]   hold_idx;
    bit           hold_v = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_v = 0;
        end else begin
            if (cfg_err) seen_err++;
            if (out_valid && hold_v) begin
                check("stall_mask_stable", out_lane_mask, hold_mask);
                check("stall_idx_stable", 256'(out_chunk_idx), 256'(hold_idx));
            end
            if (out_valid && out_ready) begin
                hold_v = 0;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_idx=%0d required=no_output", out_chunk_idx);
                end else begin
                    e = sb_q.pop_front();
                    check("lane_mask", out_lane_mask, e.mask);
                    check("lane_cnt", 256'(out_lane_cnt), 256'(e.cnt));
                    check("lane_any", 256'(out_lane_any), 256'(e.any));
                    check("chunk_idx", 256'(out_chunk_idx), 256'(e.idx));
                    check("out_uf", 256'(out_uf), 256'(e.uf));
                    check("out_last", 256'(out_last), 256'(e.last));
                end
            end else if (out_valid) begin
                hold_v = 1;
                hold_mask = out_lane_mask;
                hold_idx = out_chunk_idx;
            end else begin
                hold_v = 0;
            end
        end
    end

    // Present one chunk until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [255:0] m, input logic [1:0] uf, input logic last);
        int  t = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_mask = m;
        in_uf = uf;
        in_last = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(m, uf, last);
                done = 1;
            end else if (++t > 500) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=in_ready_low required=accept");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while (sb_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", 256'(sb_q.size()), 256'd0);
    endtask

    task automatic set_rdy(input int mode);
        @(negedge clk);
        rdy_mode = mode;
        @(posedge clk);
        #2;
    endtask

    logic [255:0] v;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_in_ready", 256'(in_ready), 256'd1);
        check("rst_chunk_idx", 256'(out_chunk_idx), 256'd0);
        check("rst_lane_mask", out_lane_mask, 256'd0);
        check("rst_cfg_err", 256'(cfg_err), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-bit mapping probes and pipeline latency.
        v = 256'd1 << 70;
        send(v, 2'd0, 1'b1);
        in_valid = 1'b0;
        check("latency_one_cycle", 256'(out_valid), 256'd0);
        @(posedge clk);
        #1;
        check("latency_two_cycles", 256'(out_valid), 256'd1);
        send(256'd1 << 144, 2'd1, 1'b1);
        send(256'd1 << 17, 2'd2, 1'b1);
        drain();

        // Backpressure: two chunks fill the pipe, the third waits.
        set_rdy(2);
        send(rand256() | 256'd1, 2'd0, 1'b0);
        send(rand256() | 256'd2, 2'd1, 1'b0);
        v = rand256() | 256'd4;
        in_valid = 1'b1;
        in_mask = v;
        in_uf = 2'd2;
        in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("in_ready_stalled", 256'(in_ready), 256'd0);
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(v, 2'd2, 1'b1);
        drain();

        // Empty-chunk skipping and illegal unroll factor.
        send(256'd0, 2'd0, 1'b0);
        send(256'hF, 2'd1, 1'b0);
        send(256'd0, 2'd2, 1'b1);
        send(rand256(), 2'd0, 1'b0);
        send(rand256(), 2'd3, 1'b0);
        send(rand256(), 2'd1, 1'b1);
        drain();

        // Random traffic with random backpressure.
        set_rdy(1);
        for (int n = 0; n < 300; n++) begin
            logic [1:0] uf;
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = 256'd1 << $urandom_range(0, 255);
                2:       v = rand256();
                default: v = rand256() & rand256() & rand256();
            endcase
            uf = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(v, uf, ($urandom_range(0, 7) == 0));
        end
        rdy_mode = 0;
        drain();

        // Reset with both stages occupied.
        set_rdy(2);
        send(rand256() | 256'd1, 2'd0, 1'b0);
        send(rand256() | 256'd1, 2'd1, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 256'(out_valid), 256'd0);
        check("async_rst_in_ready", 256'(in_ready), 256'd1);
        sb_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(rand256() | 256'd8, 2'd2, 1'b0);
        drain();

        check("cfg_err_pulses", 256'(seen_err), 256'(exp_err));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
